// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode/func encodings, ALU ops, immediate-extend modes
// and the multicycle control state/instruction-class enums.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [5:0] FN_ADD = 6'b110000;
  localparam logic [5:0] FN_SUB = 6'b110001;
  localparam logic [5:0] FN_AND = 6'b110010;
  localparam logic [5:0] FN_OR  = 6'b110011;
  localparam logic [5:0] FN_NOT = 6'b110100;
  localparam logic [5:0] FN_SRA = 6'b111000;
  localparam logic [5:0] FN_SRL = 6'b111001;
  localparam logic [5:0] FN_SLL = 6'b111010;
  localparam logic [5:0] FN_ROL = 6'b111100;
  localparam logic [5:0] FN_ROR = 6'b111101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_ROL = 4'b1100;
  localparam logic [3:0] ALU_ROR = 4'b1101;

  localparam logic [1:0] IMM_SEXT     = 2'b00;
  localparam logic [1:0] IMM_ZFILL    = 2'b01;
  localparam logic [1:0] IMM_HI16     = 2'b10;
  localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

  typedef enum logic [2:0] {RST, FETCH, DECODE, EXEC, MEM, WB} state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_BRANCH, CLS_JUMP, CLS_LOAD, CLS_STORE
  } instr_class_t;

  function automatic logic func_legal(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOT,
      FN_SRA, FN_SRL, FN_SLL, FN_ROL, FN_ROR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode: classifies the latched instruction and
// produces the ALU-stage selects used by the control FSM.
module alu_ctrl_decode
  import cpu_defs_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t instr_class,
  output logic [3:0]   alu_func,
  output logic [1:0]   imm_ext,
  output logic         alu_bin_sel,
  output logic         alu_rf_a_sel,
  output logic         branch_ne,
  output logic         byte_op,
  output logic         legal
);

  logic [5:0] opcode;
  logic [5:0] func;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign func          = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    instr_class  = CLS_ALU;
    alu_func     = ALU_ADD;
    imm_ext      = IMM_SEXT;
    alu_bin_sel  = 1'b0;
    alu_rf_a_sel = 1'b0;
    branch_ne    = 1'b0;
    byte_op      = 1'b0;
    legal        = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        alu_func = func[3:0];
        legal    = func_legal(func);
      end
      OP_ADDI: alu_bin_sel = 1'b1;
      OP_ANDI: begin
        alu_func    = ALU_AND;
        alu_bin_sel = 1'b1;
        imm_ext     = IMM_ZFILL;
      end
      OP_ORI: begin
        alu_func    = ALU_OR;
        alu_bin_sel = 1'b1;
        imm_ext     = IMM_ZFILL;
      end
      OP_LI: begin
        alu_rf_a_sel = 1'b1;
        alu_bin_sel  = 1'b1;
      end
      OP_LUI: begin
        alu_rf_a_sel = 1'b1;
        alu_bin_sel  = 1'b1;
        imm_ext      = IMM_HI16;
      end
      OP_B: begin
        instr_class = CLS_JUMP;
        imm_ext     = IMM_SEXT_SH2;
      end
      OP_BEQ, OP_BNE: begin
        instr_class = CLS_BRANCH;
        alu_func    = ALU_SUB;
        imm_ext     = IMM_SEXT_SH2;
        branch_ne   = (opcode == OP_BNE);
      end
      OP_LB, OP_LW: begin
        instr_class = CLS_LOAD;
        alu_bin_sel = 1'b1;
        byte_op     = (opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        instr_class = CLS_STORE;
        alu_bin_sel = 1'b1;
        byte_op     = (opcode == OP_SB);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle CPU control unit: state register, memory wait counter and
// per-state gating of the decoded datapath controls.
module alu_ctrl_fsm
  import cpu_defs_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        Instr_LdEn,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic [1:0]  ImmExt,
  output logic        ALU_RF_A_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_Req,
  output logic        Mem_WrEn,
  output logic        ByteOp,
  output logic        Illegal,
  output logic        Mem_Err
);

  state_t       state, state_nxt;
  logic [3:0]   wait_cnt;
  instr_class_t cls;
  logic [3:0]   dec_func;
  logic [1:0]   dec_imm;
  logic         dec_bin_sel, dec_a_sel, dec_ne, dec_byte, dec_legal;
  logic         timeout_hit;

  alu_ctrl_decode u_decode (
    .instr        (Instr),
    .instr_class  (cls),
    .alu_func     (dec_func),
    .imm_ext      (dec_imm),
    .alu_bin_sel  (dec_bin_sel),
    .alu_rf_a_sel (dec_a_sel),
    .branch_ne    (dec_ne),
    .byte_op      (dec_byte),
    .legal        (dec_legal)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= RST;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == MEM) ? wait_cnt + 4'd1 : '0;
    end
  end

  // Counter holds completed wait cycles, so the limit is hit on MEM cycle MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT != 0) &&
                       (({28'd0, wait_cnt} + 32'd1) == 32'(MEM_TIMEOUT));

  always_comb begin
    state_nxt     = state;
    Instr_LdEn    = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ImmExt        = '0;
    ALU_RF_A_sel  = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = '0;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Illegal       = 1'b0;
    Mem_Err       = 1'b0;
    case (state)
      RST: state_nxt = FETCH;
      FETCH: begin
        Instr_LdEn = 1'b1;
        PC_LdEn    = 1'b1;
        state_nxt  = DECODE;
      end
      DECODE: begin
        if (!dec_legal) begin
          Illegal   = 1'b1;
          state_nxt = FETCH;
        end else if (cls == CLS_JUMP) begin
          PC_LdEn   = 1'b1;
          PC_sel    = 1'b1;
          ImmExt    = IMM_SEXT_SH2;
          state_nxt = FETCH;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        ALU_func     = dec_func;
        ALU_Bin_sel  = dec_bin_sel;
        ALU_RF_A_sel = dec_a_sel;
        ImmExt       = dec_imm;
        case (cls)
          CLS_BRANCH: begin
            RF_B_sel  = 1'b1;
            PC_sel    = 1'b1;
            PC_LdEn   = Zero ^ dec_ne;
            state_nxt = FETCH;
          end
          CLS_LOAD:  state_nxt = MEM;
          CLS_STORE: begin
            RF_B_sel  = 1'b1;
            state_nxt = MEM;
          end
          default:   state_nxt = WB;
        endcase
      end
      MEM: begin
        ALU_func    = dec_func;
        ALU_Bin_sel = dec_bin_sel;
        ImmExt      = dec_imm;
        RF_B_sel    = (cls == CLS_STORE);
        Mem_Req     = 1'b1;
        Mem_WrEn    = (cls == CLS_STORE);
        ByteOp      = dec_byte;
        if (Mem_Ready) begin
          state_nxt = (cls == CLS_LOAD) ? WB : FETCH;
        end else if (timeout_hit) begin
          Mem_Err   = 1'b1;
          state_nxt = FETCH;
        end
      end
      WB: begin
        ALU_func      = dec_func;
        ALU_Bin_sel   = dec_bin_sel;
        ALU_RF_A_sel  = dec_a_sel;
        ImmExt        = dec_imm;
        RF_WrEn       = 1'b1;
        RF_WrData_sel = (cls == CLS_LOAD);
        state_nxt     = FETCH;
      end
      default: state_nxt = RST;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm; every output is packed into one
// vector and compared against hand-built expected patterns each cycle.
module tb_alu_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Instr;
  logic        Zero;
  logic        Mem_Ready;
  logic        Instr_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic [1:0]  ImmExt;
  logic        ALU_RF_A_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_Req, Mem_WrEn, ByteOp, Illegal, Mem_Err;

  int checks = 0;
  int errors = 0;

  alu_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Instr         (Instr),
    .Zero          (Zero),
    .Mem_Ready     (Mem_Ready),
    .Instr_LdEn    (Instr_LdEn),
    .PC_sel        (PC_sel),
    .PC_LdEn       (PC_LdEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ImmExt        (ImmExt),
    .ALU_RF_A_sel  (ALU_RF_A_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .Mem_Req       (Mem_Req),
    .Mem_WrEn      (Mem_WrEn),
    .ByteOp        (ByteOp),
    .Illegal       (Illegal),
    .Mem_Err       (Mem_Err)
  );

  always #5 Clk = ~Clk;

  logic [18:0] outs;
  assign outs = {Instr_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                 ImmExt, ALU_RF_A_sel, ALU_Bin_sel, ALU_func,
                 Mem_Req, Mem_WrEn, ByteOp, Illegal, Mem_Err};

  localparam logic [18:0] NONE = 19'h00000;
  localparam logic [18:0] ILD  = 19'h40000;
  localparam logic [18:0] PSEL = 19'h20000;
  localparam logic [18:0] PLD  = 19'h10000;
  localparam logic [18:0] RFW  = 19'h08000;
  localparam logic [18:0] RFD  = 19'h04000;
  localparam logic [18:0] RFB  = 19'h02000;
  localparam logic [18:0] ASEL = 19'h00400;
  localparam logic [18:0] BSEL = 19'h00200;
  localparam logic [18:0] MREQ = 19'h00010;
  localparam logic [18:0] MWR  = 19'h00008;
  localparam logic [18:0] BYT  = 19'h00004;
  localparam logic [18:0] ILL  = 19'h00002;
  localparam logic [18:0] MERR = 19'h00001;
  localparam logic [18:0] FET  = ILD | PLD;

  function automatic logic [18:0] imm(input logic [1:0] v);
    return {6'd0, v, 11'd0};
  endfunction

  function automatic logic [18:0] fn(input logic [3:0] v);
    return {10'd0, v, 5'd0};
  endfunction

  task automatic chk(input string tag, input logic [18:0] expected);
    checks++;
    assert (outs === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h", tag, outs, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset_n   = 1'b0;
    Instr     = '0;
    Zero      = 1'b0;
    Mem_Ready = 1'b0;
    repeat (3) step();
    chk("reset_held", NONE);
    Reset_n = 1'b1;
    #1 chk("rst_after_release", NONE);
    step(); chk("first_fetch", FET);

    // R-type sub
    Instr = 32'h80A41831;
    step(); chk("sub_decode", NONE);
    step(); chk("sub_exec", fn(4'b0001));
    step(); chk("sub_wb", RFW | fn(4'b0001));
    step(); chk("sub_fetch", FET);

    // li
    Instr = 32'hE0050007;
    step(); chk("li_decode", NONE);
    step(); chk("li_exec", ASEL | BSEL);
    step(); chk("li_wb", RFW | ASEL | BSEL);
    step(); chk("li_fetch", FET);

    // lui
    Instr = 32'hE4000000;
    step(); step(); chk("lui_exec", ASEL | BSEL | imm(2'b10));
    step(); chk("lui_wb", RFW | ASEL | BSEL | imm(2'b10));
    step(); chk("lui_fetch", FET);

    // andi
    Instr = 32'hC8000000;
    step(); step(); chk("andi_exec", BSEL | imm(2'b01) | fn(4'b0010));
    step(); step(); chk("andi_fetch", FET);

    // beq, Zero toggled within EXEC
    Instr = 32'h00000004;
    Zero  = 1'b1;
    step(); chk("beq_decode", NONE);
    step(); chk("beq_exec_z1", RFB | PSEL | PLD | imm(2'b11) | fn(4'b0001));
    Zero = 1'b0;
    #1 chk("beq_exec_z0", RFB | PSEL | imm(2'b11) | fn(4'b0001));
    step(); chk("beq_fetch", FET);

    // bne
    Instr = 32'h04000004;
    step(); step(); chk("bne_exec_z0", RFB | PSEL | PLD | imm(2'b11) | fn(4'b0001));
    Zero = 1'b1;
    #1 chk("bne_exec_z1", RFB | PSEL | imm(2'b11) | fn(4'b0001));
    Zero = 1'b0;
    step(); chk("bne_fetch", FET);

    // lw, Mem_Ready on the 3rd MEM cycle; Mem_Ready high in FETCH is ignored
    Instr     = 32'h3C000010;
    Mem_Ready = 1'b1;
    step(); chk("lw_decode", NONE);
    Mem_Ready = 1'b0;
    step(); chk("lw_exec", BSEL);
    step(); chk("lw_mem1", BSEL | MREQ);
    step(); chk("lw_mem2", BSEL | MREQ);
    step(); Mem_Ready = 1'b1;
    #1 chk("lw_mem3", BSEL | MREQ);
    step(); Mem_Ready = 1'b0;
    #1 chk("lw_wb", RFW | RFD | BSEL);
    step(); chk("lw_fetch", FET);

    // sb, immediate ready
    Instr = 32'h1C000000;
    step(); step(); chk("sb_exec", RFB | BSEL);
    step(); Mem_Ready = 1'b1;
    #1 chk("sb_mem", RFB | BSEL | MREQ | MWR | BYT);
    step(); Mem_Ready = 1'b0;
    #1 chk("sb_fetch", FET);

    // sw, never ready: 15 MEM cycles, Mem_Err on the last
    Instr = 32'h7C000010;
    step(); step(); chk("sw_exec", RFB | BSEL);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("sw_wait%0d", i),
          RFB | BSEL | MREQ | MWR | ((i == 14) ? MERR : NONE));
    end
    step(); chk("sw_timeout_fetch", FET);

    // lb, ready arrives exactly at the limit: success, no Mem_Err
    Instr = 32'h0C000000;
    step(); step(); chk("lb_exec", BSEL);
    for (int i = 0; i < 14; i++) step();
    chk("lb_mem14", BSEL | MREQ | BYT);
    step(); Mem_Ready = 1'b1;
    #1 chk("lb_mem15_ready", BSEL | MREQ | BYT);
    step(); Mem_Ready = 1'b0;
    #1 chk("lb_wb", RFW | RFD | BSEL);
    step(); chk("lb_fetch", FET);

    // undefined opcode 0x2A
    Instr = 32'hA8000000;
    step(); chk("illegal_op", ILL);
    step(); chk("illegal_op_fetch", FET);

    // R-type with undefined func
    Instr = 32'h80000000;
    step(); chk("illegal_func", ILL);
    step(); chk("illegal_func_fetch", FET);

    // unconditional branch
    Instr = 32'hFC000001;
    step(); chk("b_decode", PSEL | PLD | imm(2'b11));
    step(); chk("b_fetch", FET);

    // reset asserted mid-MEM
    Instr = 32'h3C000010;
    step(); step(); step(); chk("rst_mid_mem_pre", BSEL | MREQ);
    #1 Reset_n = 1'b0;
    #1 chk("rst_mid_mem_async", NONE);
    step(); chk("rst_mid_mem_held", NONE);
    Reset_n = 1'b1;
    step(); chk("rst_mid_mem_refetch", FET);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle control unit for the CPU datapath.
- Decodes the latched instruction and, state by state, drives the ALU stage selects (ALU_RF_A_sel, ALU_Bin_sel, ALU_func), the register file, PC and data-memory controls.
- Waits on a data-memory ready handshake for loads and stores.
- Sits between the instruction register and the IF/DEC/ALU/MEM stages; one instance per core.

Parameters:
- MEM_TIMEOUT, 15: cycles to wait for Mem_Ready before aborting to FETCH and pulsing Mem_Err; 0 means wait forever.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register contents; stable outside FETCH.
- Zero  in  1  ALU zero flag, combinational from the ALU stage.
- Mem_Ready  in  1  data memory completes the current access.
- Instr_LdEn  out  1  load instruction register.
- PC_sel  out  1  0: PC+4, 1: PC+4+(SignExt(imm)<<2).
- PC_LdEn  out  1  PC write enable.
- RF_WrEn  out  1  register file write enable.
- RF_WrData_sel  out  1  0: ALU_out, 1: memory data.
- RF_B_sel  out  1  0: rt (Instr[15:11]), 1: rd (Instr[20:16]).
- ImmExt  out  2  00 sign-extend, 01 zero-fill, 10 <<16 zero-fill, 11 sign-extend <<2.
- ALU_RF_A_sel  out  1  1 forces ALU A = 0.
- ALU_Bin_sel  out  1  1 selects Immed as ALU B.
- ALU_func  out  4  ALU op.
- Mem_Req  out  1  data-memory access request.
- Mem_WrEn  out  1  write access when Mem_Req is high.
- ByteOp  out  1  byte access (lb/sb).
- Illegal  out  1  one-cycle pulse on an undefined opcode or func.
- Mem_Err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Decode fields: opcode = Instr[31:26], func = Instr[5:0].
- Opcodes: R-type 100000; li 111000; lui 111001; addi 110000; andi 110010; ori 110011; b 111111; beq 000000; bne 000001; lb 000011; lw 001111; sb 000111; sw 011111.
- R-type legal funcs: 110000 add, 110001 sub, 110010 and, 110011 or, 110100 not, 111000 sra, 111001 srl, 111010 sll, 111100 rol, 111101 ror. For these, ALU_func = func[3:0].
- State register is asynchronously reset to RST while Reset_n is low. All outputs are 0 in RST.
- RST -> FETCH on the first rising edge after Reset_n deasserts.
- Outputs are combinational from the current state and Instr. Every output not listed for a state is 0.
- FETCH: Instr_LdEn=1, PC_LdEn=1, PC_sel=0. Goes to DECODE.
- DECODE:
  - Defined opcode/func: go to EXEC.
  - Undefined: Illegal=1, go to FETCH; no architectural write.
  - b: PC_LdEn=1, PC_sel=1, ImmExt=11, go to FETCH.
- EXEC:
  - R-type: ALU_Bin_sel=0, ALU_func=func[3:0], go to WB.
  - addi: ALU_func=0000, ALU_Bin_sel=1, ImmExt=00, go to WB.
  - andi, ori: ALU_func=0010/0011, ALU_Bin_sel=1, ImmExt=01, go to WB.
  - li: ALU_RF_A_sel=1, ALU_Bin_sel=1, ALU_func=0000, ImmExt=00, go to WB.
  - lui: same as li with ImmExt=10, go to WB.
  - beq, bne: RF_B_sel=1, ALU_func=0001, ALU_Bin_sel=0, ImmExt=11, PC_sel=1. PC_LdEn = Zero for beq, ~Zero for bne. Go to FETCH.
  - lb, lw, sb, sw: ALU_func=0000, ALU_Bin_sel=1, ImmExt=00, go to MEM.
  - sb/sw additionally set RF_B_sel=1.
- MEM:
  - Holds the EXEC address controls and asserts Mem_Req=1, Mem_WrEn (stores), ByteOp (lb/sb).
  - Stays in MEM until Mem_Ready=1.
  - Loads then go to WB. Stores go to FETCH.
  - Wait counter is 4 bits, cleared on MEM entry. If MEM_TIMEOUT is nonzero and the counter reaches MEM_TIMEOUT without Mem_Ready: Mem_Err=1, go to FETCH.
  - Mem_Ready in the same cycle the counter hits the limit counts as success.
- WB:
  - Holds the EXEC ALU controls and sets RF_WrEn=1.
  - RF_WrData_sel=1 for loads, else 0.
  - Goes to FETCH.
- Latencies: R/I ALU = 4 cycles; branch = 3; b = 2; store = 3+waits; load = 4+waits.
- Reset_n low in any state, including mid-MEM: return to RST immediately. Mem_Req and all write enables drop asynchronously.
- Mem_Ready outside MEM is ignored.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - opcode and func localparams;
  - ALU op codes (ALU_ADD 0000 … ALU_ROR 1101);
  - ImmExt encodings;
  - the state enum (RST, FETCH, DECODE, EXEC, MEM, WB).
- Sub-module alu_ctrl_decode: purely combinational. Instr -> instruction class, ALU_func, ImmExt, ALU_Bin_sel, ALU_RF_A_sel, legal flag. The FSM module holds the state register, wait counter and per-state output gating.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles, release -> all outputs 0 in RST; next cycle FETCH with Instr_LdEn=1, PC_LdEn=1, PC_sel=0.
- R-type: Instr=0x80A41831 (add r4,r5,r3? func 110001=sub) -> EXEC shows ALU_func=0001, ALU_Bin_sel=0; WB has RF_WrEn=1, RF_WrData_sel=0; back in FETCH after 4 cycles.
- li: Instr=0xE0050007 -> EXEC shows ALU_RF_A_sel=1, ALU_Bin_sel=1, ImmExt=00, ALU_func=0000; WB has RF_WrEn=1.
- Branches: beq with Zero=1 -> EXEC PC_LdEn=1, PC_sel=1. Same with Zero=0 -> PC_LdEn=0. bne inverts both results.
- Load with waits: lw, Mem_Ready asserted on the 3rd MEM cycle -> Mem_Req high for exactly 3 cycles, Mem_WrEn=0; WB has RF_WrData_sel=1, RF_WrEn=1.
- Store timeout and reset: sw, Mem_Ready never asserted -> Mem_Req held 15 cycles, Mem_Err one pulse, then FETCH. Illegal opcode 0x2A -> Illegal pulse in DECODE, no RF_WrEn. Reset_n low mid-MEM -> Mem_Req 0 immediately.
